csr_regfile: RTL
================

# csr_regfile

Control/status register file for the five-stage LoongArch pipeline: the responder for the CSR write port driven from writeback (number, write enable, value, mask), the combinational CSR read port used by decode, and the exception/`ertn` commit port. Holds CRMD, PRMD, ECFG, ESTAT, ERA, EENTRY, SAVE0–3 and the optional stable timer. Produces the exception and return entry addresses and the interrupt-pending flag for the front end.

## Interface
- No parameters; CSR numbers and field positions come from the shared package.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `csr_rnum` in 14: read CSR number.
- `csr_rvalue` out 32: read data, combinational; unmapped numbers return 0.
- `csr_we` in 1: write strobe from WB, already qualified by WB valid.
- `csr_num` in 14: write CSR number.
- `csr_wvalue` in 32: write data.
- `csr_wmask` in 32: per-bit write mask.
- `wb_ex` in 1: exception committing in WB.
- `wb_ecode` in 6, `wb_esubcode` in 9, `wb_pc` in 32: exception cause and PC.
- `ertn_flush` in 1: `ertn` committing in WB.
- `hw_int_in` in 8, `ipi_int_in` in 1: level interrupt inputs.
- `ex_entry` out 32: EENTRY value. `ertn_entry` out 32: ERA value.
- `has_int` out 1: interrupt pending and enabled.

## Operation
- Masked write on posedge when `csr_we`: field <= (old & ~mask) | (wvalue & mask). Only architecturally writable bits change.
- Field map:
  - CRMD 0x0: PLV[1:0], IE[2], DA[3]; reset PLV=0, IE=0, DA=1.
  - PRMD 0x1: PPLV[1:0], PIE[2].
  - ECFG 0x4: LIE[12:0], bit 10 reads 0.
  - ESTAT 0x5: IS[1:0] software-writable; IS[9:2]=hw_int_in, IS[11]=timer, IS[12]=ipi (all read-only); Ecode[21:16], EsubCode[30:22].
  - ERA 0x6: full 32 bits.
  - EENTRY 0xC: VA[31:6]; low bits read 0.
  - SAVE0–3 0x30–0x33: full 32 bits.
  - TID 0x40, TCFG 0x41 (En[0], Periodic[1], InitVal[31:2]), TVAL 0x42 read-only, TICLR 0x44 (CLR[0], write-1 clears IS[11], reads 0).
- `wb_ex`:
  - PRMD.PPLV/PIE <= CRMD.PLV/IE.
  - CRMD.PLV <= 0, CRMD.IE <= 0.
  - ESTAT.Ecode/EsubCode <= inputs.
  - ERA <= `wb_pc`.
- `ertn_flush`: CRMD.PLV <= PRMD.PPLV, CRMD.IE <= PRMD.PIE.
- Priority: `wb_ex` > `ertn_flush` > `csr_we`. A write coinciding with either event is dropped in full.
- `has_int` = |(ESTAT.IS[12:0] & ECFG.LIE[12:0]) & CRMD.IE.
- All reset values are 0 except CRMD.DA=1. Reset state of the outputs:
  - `ex_entry` = 0, `ertn_entry` = 0, `has_int` = 0.
  - `csr_rvalue` returns 0x8 for CRMD and 0 for every other number.
- Timer, per cycle with En=1 and TVAL != 0xFFFF_FFFF:
  - TVAL != 0: TVAL-1.
  - TVAL == 0: set IS[11]; TVAL reloads {InitVal,2'b00} if Periodic, else 0xFFFF_FFFF, where it stops.
- A TCFG write loads TVAL <= {wvalue-derived InitVal,2'b00}.

## Timing
- Read port is combinational from current state. There is no same-cycle write bypass: a read in the write cycle returns the old value, and decode interlocks.
- Writes and events become visible one cycle after the edge on which they commit.
- `hw_int_in`/`ipi_int_in` are registered into IS: one cycle of latency to `has_int`.
- Same cycle, TICLR write and timer reaching 0: set wins, IS[11]=1.
- Same cycle, TCFG write and timer reaching 0: TCFG reload wins, IS[11] still set.
- `resetn` low mid-count clears the timer and IS immediately, independent of `clk`.

## Configuration
- `CSR_TIMER_EN` defined: TID/TCFG/TVAL/TICLR and IS[11] are implemented as above.
- Not defined:
  - TID/TCFG/TVAL/TICLR read 0 and writes are ignored.
  - IS[11] is tied to 0.
  - The timer sub-module is not instantiated.

## Structure
- Shared package `csr_pkg`: 14-bit CSR number constants, field bit positions and widths, ECODE constants (INT, SYS, ADEF, ALE, BRK, INE).
- Sub-module `csr_timer` holds TVAL, the TCFG fields and the TI flag. It takes the decoded TCFG/TICLR write strobes plus masked data and outputs `tval` and `ti`.

## Test plan
- Reset release -> `csr_rvalue`(0x0)=0x0000_0008, `ex_entry`=0, `has_int`=0.
- Write SAVE1 value 0xDEAD_BEEF mask 0x0000_FFFF over 0x1234_5678 -> reads 0x1234_BEEF next cycle; same-cycle read returns 0x1234_5678.
- CRMD=0x7, then `wb_ex` ecode 0x0B, pc 0x1C00_0040, with a simultaneous SAVE0 write:
  - CRMD=0x0, PRMD=0x7, ESTAT[21:16]=0x0B, ERA=0x1C00_0040.
  - SAVE0 unchanged.
  - `ertn_flush` then restores CRMD=0x7.
- TCFG=0x0000_000B (InitVal=2, Periodic, En) -> TVAL 8,7,…,0, then IS[11]=1 and TVAL reloads 8. With LIE[11]=1 and IE=1, `has_int`=1 one cycle later. TICLR write 1 clears IS[11].
- Non-periodic TCFG=0x9 -> TVAL counts to 0, then 0xFFFF_FFFF, and holds.
- `hw_int_in`=0x04, LIE bit 4 set, IE=1 -> `has_int`=1 after one cycle. Without `CSR_TIMER_EN`, TCFG write ignored and TVAL reads 0.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the CSR register file.
//   CSR numbers (14-bit), writable-field masks, interrupt-status bit
//   positions, exception codes and the masked-write helper.
package csr_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    // CRMD / PRMD field positions
    localparam int unsigned CRMD_PLV_LSB = 0;
    localparam int unsigned CRMD_PLV_W   = 2;
    localparam int unsigned CRMD_IE_BIT  = 2;
    localparam int unsigned CRMD_DA_BIT  = 3;

    // ESTAT field positions
    localparam int unsigned ESTAT_IS_W       = 13;
    localparam int unsigned ESTAT_IS_HW_LSB  = 2;
    localparam int unsigned ESTAT_IS_TI_BIT  = 11;
    localparam int unsigned ESTAT_IS_IPI_BIT = 12;
    localparam int unsigned ESTAT_ECODE_LSB  = 16;
    localparam int unsigned ESTAT_ESUB_LSB   = 22;

    // ECFG.LIE bit 10 has no interrupt source behind it and stays 0
    localparam logic [12:0] ECFG_LIE_WMASK = 13'h1BFF;

    typedef enum logic [5:0] {
        ECODE_INT  = 6'h00,
        ECODE_ADEF = 6'h08,
        ECODE_ALE  = 6'h09,
        ECODE_SYS  = 6'h0B,
        ECODE_BRK  = 6'h0C,
        ECODE_INE  = 6'h0D
    } ecode_e;

    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] wvalue,
                                              input logic [31:0] wmask);
        return (old_val & ~wmask) | (wvalue & wmask);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// csr_timer: stable timer (TCFG fields, TVAL down-counter, TI flag).
//   Only compiled when CSR_TIMER_EN is defined.
// Ports:
//   clk, resetn        clock, async active-low reset
//   tcfg_we, ticlr_we  decoded, already-qualified write strobes
//   wvalue, wmask      write data and per-bit mask
//   tcfg               TCFG read value {InitVal, Periodic, En}
//   tval               current counter value
//   ti                 timer interrupt flag (ESTAT.IS[11])
`ifdef CSR_TIMER_EN
module csr_timer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        tcfg_we,
    input  logic        ticlr_we,
    input  logic [31:0] wvalue,
    input  logic [31:0] wmask,
    output logic [31:0] tcfg,
    output logic [31:0] tval,
    output logic        ti
);

    logic        en;
    logic        periodic;
    logic [29:0] initval;
    logic [31:0] tcfg_new;
    logic        running;
    logic        at_zero;
    logic        ticlr_hit;

    assign tcfg      = {initval, periodic, en};
    assign tcfg_new  = csr_merge(tcfg, wvalue, wmask);
    // 0xFFFF_FFFF is the parked state of a one-shot timer
    assign running   = en && (tval != '1);
    assign at_zero   = running && (tval == '0);
    assign ticlr_hit = ticlr_we && wvalue[0] && wmask[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            initval  <= '0;
            tval     <= '0;
            ti       <= 1'b0;
        end else begin
            // A TCFG write overrides the reload, but the expiry still raises TI
            if (tcfg_we) begin
                en       <= tcfg_new[0];
                periodic <= tcfg_new[1];
                initval  <= tcfg_new[31:2];
                tval     <= {tcfg_new[31:2], 2'b00};
            end else if (running) begin
                if (at_zero)
                    tval <= periodic ? {initval, 2'b00} : '1;
                else
                    tval <= tval - 32'd1;
            end

            if (at_zero)
                ti <= 1'b1;
            else if (ticlr_hit)
                ti <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/csr_regfile.sv
// csr_regfile: LoongArch CSR register file (CRMD, PRMD, ECFG, ESTAT, ERA,
//   EENTRY, SAVE0-3, optional stable timer TID/TCFG/TVAL/TICLR).
//   Config macro: CSR_TIMER_EN enables the timer CSRs and ESTAT.IS[11].
// Ports:
//   clk, resetn                      clock, async active-low reset
//   csr_rnum / csr_rvalue            combinational read port (0 if unmapped)
//   csr_we, csr_num, csr_wvalue,
//   csr_wmask                        masked write port from WB
//   wb_ex, wb_ecode, wb_esubcode,
//   wb_pc                            exception commit
//   ertn_flush                       ertn commit
//   hw_int_in, ipi_int_in            level interrupt inputs (registered)
//   ex_entry / ertn_entry            EENTRY / ERA values
//   has_int                          enabled interrupt pending
module csr_regfile
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [13:0] csr_rnum,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [13:0] csr_num,
    input  logic [31:0] csr_wvalue,
    input  logic [31:0] csr_wmask,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);

    logic [1:0]  crmd_plv;
    logic        crmd_ie;
    logic        crmd_da;
    logic [1:0]  prmd_pplv;
    logic        prmd_pie;
    logic [12:0] ecfg_lie;
    logic [1:0]  estat_is_sw;
    logic [7:0]  estat_is_hw;
    logic        estat_is_ipi;
    logic [5:0]  estat_ecode;
    logic [8:0]  estat_esubcode;
    logic [31:0] era;
    logic [25:0] eentry_va;
    logic [31:0] save [4];

    logic        csr_wr;
    logic        timer_ti;
    logic [12:0] estat_is;
    logic [12:0] lie_wmask;

    // Exceptions and ertn drop a coinciding CSR write entirely
    assign csr_wr    = csr_we && !wb_ex && !ertn_flush;
    assign lie_wmask = csr_wmask[12:0] & ECFG_LIE_WMASK;

`ifdef CSR_TIMER_EN
    logic [31:0] tid;
    logic [31:0] timer_tcfg;
    logic [31:0] timer_tval;

    csr_timer u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .tcfg_we  (csr_wr && (csr_num == CSR_TCFG)),
        .ticlr_we (csr_wr && (csr_num == CSR_TICLR)),
        .wvalue   (csr_wvalue),
        .wmask    (csr_wmask),
        .tcfg     (timer_tcfg),
        .tval     (timer_tval),
        .ti       (timer_ti)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            tid <= '0;
        else if (csr_wr && (csr_num == CSR_TID))
            tid <= csr_merge(tid, csr_wvalue, csr_wmask);
    end
`else
    assign timer_ti = 1'b0;
`endif

    assign estat_is = {estat_is_ipi, timer_ti, 1'b0, estat_is_hw, estat_is_sw};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_plv       <= '0;
            crmd_ie        <= 1'b0;
            crmd_da        <= 1'b1;
            prmd_pplv      <= '0;
            prmd_pie       <= 1'b0;
            ecfg_lie       <= '0;
            estat_is_sw    <= '0;
            estat_is_hw    <= '0;
            estat_is_ipi   <= 1'b0;
            estat_ecode    <= '0;
            estat_esubcode <= '0;
            era            <= '0;
            eentry_va      <= '0;
            for (int unsigned i = 0; i < 4; i++)
                save[i] <= '0;
        end else begin
            estat_is_hw  <= hw_int_in;
            estat_is_ipi <= ipi_int_in;

            if (wb_ex) begin
                prmd_pplv      <= crmd_plv;
                prmd_pie       <= crmd_ie;
                crmd_plv       <= '0;
                crmd_ie        <= 1'b0;
                estat_ecode    <= wb_ecode;
                estat_esubcode <= wb_esubcode;
                era            <= wb_pc;
            end else if (ertn_flush) begin
                crmd_plv <= prmd_pplv;
                crmd_ie  <= prmd_pie;
            end else if (csr_we) begin
                case (csr_num)
                    CSR_CRMD: begin
                        crmd_plv <= (crmd_plv & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
                        if (csr_wmask[CRMD_IE_BIT]) crmd_ie <= csr_wvalue[CRMD_IE_BIT];
                        if (csr_wmask[CRMD_DA_BIT]) crmd_da <= csr_wvalue[CRMD_DA_BIT];
                    end
                    CSR_PRMD: begin
                        prmd_pplv <= (prmd_pplv & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
                        if (csr_wmask[2]) prmd_pie <= csr_wvalue[2];
                    end
                    CSR_ECFG:
                        ecfg_lie <= (ecfg_lie & ~lie_wmask) | (csr_wvalue[12:0] & lie_wmask);
                    CSR_ESTAT:
                        estat_is_sw <= (estat_is_sw & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
                    CSR_ERA:
                        era <= csr_merge(era, csr_wvalue, csr_wmask);
                    CSR_EENTRY:
                        eentry_va <= (eentry_va & ~csr_wmask[31:6]) | (csr_wvalue[31:6] & csr_wmask[31:6]);
                    CSR_SAVE0: save[0] <= csr_merge(save[0], csr_wvalue, csr_wmask);
                    CSR_SAVE1: save[1] <= csr_merge(save[1], csr_wvalue, csr_wmask);
                    CSR_SAVE2: save[2] <= csr_merge(save[2], csr_wvalue, csr_wmask);
                    CSR_SAVE3: save[3] <= csr_merge(save[3], csr_wvalue, csr_wmask);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        csr_rvalue = '0;
        case (csr_rnum)
            CSR_CRMD:   csr_rvalue = {28'b0, crmd_da, crmd_ie, crmd_plv};
            CSR_PRMD:   csr_rvalue = {29'b0, prmd_pie, prmd_pplv};
            CSR_ECFG:   csr_rvalue = {19'b0, ecfg_lie};
            CSR_ESTAT:  csr_rvalue = {1'b0, estat_esubcode, estat_ecode, 3'b0, estat_is};
            CSR_ERA:    csr_rvalue = era;
            CSR_EENTRY: csr_rvalue = {eentry_va, 6'b0};
            CSR_SAVE0:  csr_rvalue = save[0];
            CSR_SAVE1:  csr_rvalue = save[1];
            CSR_SAVE2:  csr_rvalue = save[2];
            CSR_SAVE3:  csr_rvalue = save[3];
`ifdef CSR_TIMER_EN
            CSR_TID:    csr_rvalue = tid;
            CSR_TCFG:   csr_rvalue = timer_tcfg;
            CSR_TVAL:   csr_rvalue = timer_tval;
`endif
            default:    csr_rvalue = '0;
        endcase
    end

    assign ex_entry   = {eentry_va, 6'b0};
    assign ertn_entry = era;
    assign has_int    = (|(estat_is & ecfg_lie)) && crmd_ie;

endmodule
